bcd_seg_display_ctrl: RTL and testbench

//  Parametrised, sequential binary-to-decimal seven-segment display driver for sensor and timer readouts.
//  - Converts a BIN_W-bit unsigned value to DIGITS BCD digits using iterative double-dabble, one shift per clock.
//  - Drives DIGITS active-low seven-segment digits from the converted value.
//  - Display options: leading-zero blanking, overflow indication and a programmable blink.

---
 rtl/bcd_seg_display_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bcd_seg_display_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_display_ctrl.sv
// bcd_seg_display_ctrl
// Sequential double-dabble binary-to-BCD converter that drives a row of
// active-low seven-segment digits. It supports leading-zero blanking, an
// overflow dash pattern and a whole-display blink. One shift is performed per
// clock. The result registers and the blink state feed a purely combinational
// segment decoder.
module bcd_seg_display_ctrl #(
  parameter int BIN_W     = 8,
  parameter int DIGITS    = 3,
  parameter int BLINK_DIV = 50000000,
  parameter int BLANK_LZ  = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out
);

  // Scratch digit count is ceil(BIN_W*log10(2))+1, computed in fixed point.
  // It is widened to at least DIGITS so that the low-digit slice always exists.
  localparam int SCR_MIN = (BIN_W * 30103 + 99999) / 100000 + 1;
  localparam int SCR_D   = (SCR_MIN > DIGITS) ? SCR_MIN : DIGITS;
  localparam int SCR_W   = 4 * SCR_D;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [BIN_W-1:0]    r_bin;
  logic [SCR_W-1:0]    r_scr;
  logic [CNT_W-1:0]    r_cnt;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_ovf;
  logic                r_done;
  logic [BLK_W-1:0]    r_blk_cnt;
  logic                r_phase;      // 1 = blank half of the blink period

  logic [SCR_W-1:0]    w_adj;
  logic                w_ovf;
  logic                w_accept;
  logic [DIGITS-1:0]   w_lz;
  logic [7*DIGITS-1:0] w_seg;

  // A load is honoured whenever no shift sequence is running, including the DONE cycle.
  assign w_accept = load && (r_state != S_SHIFT);

  // Double-dabble correction: add 3 to every scratch nibble >= 5 before shifting.
  always_comb begin
    w_adj = '0;
    for (int d = 0; d < SCR_D; d++) begin
      if (r_scr[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
      else                         w_adj[4*d +: 4] = r_scr[4*d +: 4];
    end
  end

  // Any nonzero scratch digit above the displayed ones means the value does not fit.
  generate
    if (SCR_D > DIGITS) begin : g_ovf
      assign w_ovf = |r_scr[SCR_W-1:4*DIGITS];
    end else begin : g_no_ovf
      assign w_ovf = 1'b0;
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic. The last shift happens while the counter reads 1.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (load) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      S_DONE:  w_next = load ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Conversion datapath: capture the input, shift it through the scratch, and latch the result.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_bin  <= '0;
      r_scr  <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_SHIFT) begin
        {r_scr, r_bin} <= {w_adj[SCR_W-2:0], r_bin, 1'b0};
        r_cnt          <= r_cnt - CNT_W'(1);
      end
      if (r_state == S_DONE) begin
        r_bcd  <= r_scr[4*DIGITS-1:0];
        r_ovf  <= w_ovf;
        r_done <= 1'b1;
      end
      if (w_accept) begin
        r_bin <= bin_in;
        r_scr <= '0;
        r_cnt <= CNT_W'(BIN_W);
      end
    end
  end

  // Blink timebase: the phase toggles every BLINK_DIV enabled cycles and returns to visible when disabled.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (!blink_en) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (r_blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
      r_blk_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_blk_cnt <= r_blk_cnt + BLK_W'(1);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Segment decode. w_lz[k] marks digit k as zero with every digit above it also zero.
  always_comb begin
    logic v_allz;
    v_allz = 1'b1;
    w_lz   = '0;
    w_seg  = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v_allz  = v_allz && (r_bcd[4*k +: 4] == 4'd0);
      w_lz[k] = v_allz;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (r_phase)                              w_seg[7*k +: 7] = SEG_BLANK;
      else if (r_ovf)                           w_seg[7*k +: 7] = SEG_DASH;
      else if ((BLANK_LZ != 0) && (k > 0) && w_lz[k]) w_seg[7*k +: 7] = SEG_BLANK;
      else                                      w_seg[7*k +: 7] = seg7(r_bcd[4*k +: 4]);
    end
  end

  assign busy     = (r_state == S_SHIFT);
  assign done     = r_done;
  assign overflow = r_ovf;
  assign bcd_out  = r_bcd;
  assign seg_out  = w_seg;

endmodule

// File: tb/tb_bcd_seg_display_ctrl.sv
// Directed testbench for bcd_seg_display_ctrl. It uses a 3-digit instance
// and a 2-digit instance that share the same stimulus.
module tb_bcd_seg_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111, SD = 7'b0111111;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic [7:0]  bin_in   = '0;
  logic        load     = 1'b0;
  logic        blink_en = 1'b0;

  logic        busy, done, overflow;
  logic [11:0] bcd_out;
  logic [20:0] seg_out;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd_out2;
  logic [13:0] seg_out2;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_seg_display_ctrl #(.BIN_W(8), .DIGITS(3), .BLINK_DIV(4), .BLANK_LZ(1)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .bin_in(bin_in), .load(load), .blink_en(blink_en),
    .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out), .seg_out(seg_out)
  );

  bcd_seg_display_ctrl #(.BIN_W(8), .DIGITS(2), .BLINK_DIV(4), .BLANK_LZ(1)) dut2 (
    .CLOCK_50(CLOCK_50), .reset(reset), .bin_in(bin_in), .load(load), .blink_en(blink_en),
    .busy(busy2), .done(done2), .overflow(overflow2), .bcd_out(bcd_out2), .seg_out(seg_out2)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  // Load a value and count edges after the sampling edge until done, with a bounded wait.
  task automatic convert(input logic [7:0] v, output int edges, output int busy_cnt);
    bin_in = v;
    load   = 1'b1;
    tick();
    load     = 1'b0;
    busy_cnt = busy ? 1 : 0;
    edges    = 0;
    while (edges < 30) begin
      tick();
      edges++;
      if (done) break;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    n_tests++; if (bcd_out !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got %h exp 000", bcd_out); end
    n_tests++; if (seg_out !== {SB, SB, S0}) begin n_fail++; $display("FAIL reset_seg got %b exp %b", seg_out, {SB, SB, S0}); end
    n_tests++; if (seg_out2 !== {SB, S0}) begin n_fail++; $display("FAIL reset_seg2 got %b exp %b", seg_out2, {SB, S0}); end
    reset = 1'b1;
    tick();
    n_tests++; if (seg_out !== {SB, SB, S0} || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset got seg %b busy %b", seg_out, busy); end
  endtask

  task automatic test_convert_255();
    int e, b;
    convert(8'd255, e, b);
    n_tests++; if (e !== 9) begin n_fail++; $display("FAIL lat_255 got %0d exp 9", e); end
    n_tests++; if (b !== 8) begin n_fail++; $display("FAIL busy_255 got %0d exp 8", b); end
    n_tests++; if (bcd_out !== 12'h255) begin n_fail++; $display("FAIL bcd_255 got %h exp 255", bcd_out); end
    n_tests++; if (seg_out !== {S2, S5, S5}) begin n_fail++; $display("FAIL seg_255 got %b exp %b", seg_out, {S2, S5, S5}); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_255 got %b exp 0", overflow); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b exp 0", done); end
  endtask

  task automatic test_blanking();
    int e, b;
    convert(8'd7, e, b);
    n_tests++; if (seg_out !== {SB, SB, S7}) begin n_fail++; $display("FAIL seg_7 got %b exp %b", seg_out, {SB, SB, S7}); end
    convert(8'd100, e, b);
    n_tests++; if (bcd_out !== 12'h100) begin n_fail++; $display("FAIL bcd_100 got %h exp 100", bcd_out); end
    n_tests++; if (seg_out !== {S1, S0, S0}) begin n_fail++; $display("FAIL seg_100 got %b exp %b", seg_out, {S1, S0, S0}); end
    convert(8'd205, e, b);
    n_tests++; if (seg_out !== {S2, S0, S5}) begin n_fail++; $display("FAIL seg_205 got %b exp %b", seg_out, {S2, S0, S5}); end
  endtask

  task automatic test_overflow();
    int e, b;
    convert(8'd150, e, b);
    n_tests++; if (overflow2 !== 1'b1) begin n_fail++; $display("FAIL ovf2_150 got %b exp 1", overflow2); end
    n_tests++; if (bcd_out2 !== 8'h50) begin n_fail++; $display("FAIL bcd2_150 got %h exp 50", bcd_out2); end
    n_tests++; if (seg_out2 !== {SD, SD}) begin n_fail++; $display("FAIL seg2_150 got %b exp %b", seg_out2, {SD, SD}); end
    n_tests++; if (overflow !== 1'b0 || bcd_out !== 12'h150) begin n_fail++; $display("FAIL d3_150 got ovf %b bcd %h exp 0 150", overflow, bcd_out); end
    convert(8'd99, e, b);
    n_tests++; if (overflow2 !== 1'b0) begin n_fail++; $display("FAIL ovf2_99 got %b exp 0", overflow2); end
    n_tests++; if (seg_out2 !== {S9, S9}) begin n_fail++; $display("FAIL seg2_99 got %b exp %b", seg_out2, {S9, S9}); end
  endtask

  task automatic test_blink();
    logic [20:0] vis;
    logic [20:0] exp_seg;
    vis = {SB, S9, S9};
    blink_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_seg = (((i / 4) % 2) == 1) ? {SB, SB, SB} : vis;
      n_tests++; if (seg_out !== exp_seg) begin n_fail++; $display("FAIL blink_c%0d got %b exp %b", i, seg_out, exp_seg); end
    end
    blink_en = 1'b0;
    tick();
    n_tests++; if (seg_out !== vis) begin n_fail++; $display("FAIL blink_off got %b exp %b", seg_out, vis); end
    tick();
    n_tests++; if (seg_out !== vis) begin n_fail++; $display("FAIL blink_hold got %b exp %b", seg_out, vis); end
  endtask

  task automatic test_ignore_load();
    int ndone;
    logic [11:0] res;
    ndone  = 0;
    res    = '0;
    bin_in = 8'd123;
    load   = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    bin_in = 8'd42;
    load   = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin ndone++; res = bcd_out; end
    end
    n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL ign_done_cnt got %0d exp 1", ndone); end
    n_tests++; if (res !== 12'h123) begin n_fail++; $display("FAIL ign_bcd got %h exp 123", res); end
  endtask

  task automatic test_reset_abort();
    int ndone;
    ndone  = 0;
    bin_in = 8'd200;
    load   = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
    n_tests++; if (bcd_out !== 12'h000) begin n_fail++; $display("FAIL abort_bcd got %h exp 000", bcd_out); end
    n_tests++; if (seg_out !== {SB, SB, S0}) begin n_fail++; $display("FAIL abort_seg got %b exp %b", seg_out, {SB, SB, S0}); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_done got %0d exp 0", ndone); end
    n_tests++; if (bcd_out !== 12'h000 || overflow !== 1'b0) begin n_fail++; $display("FAIL abort_hold got bcd %h ovf %b exp 000 0", bcd_out, overflow); end
  endtask

  task automatic test_back_to_back();
    int e;
    bin_in = 8'd45;
    load   = 1'b1;
    tick();
    load = 1'b0;
    e    = 0;
    while (busy && e < 20) begin tick(); e++; end
    n_tests++; if (e !== 8 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_donestate got %0d done %b exp 8 0", e, done); end
    bin_in = 8'd67;
    load   = 1'b1;
    tick();
    load = 1'b0;
    n_tests++; if (done !== 1'b1 || bcd_out !== 12'h045) begin n_fail++; $display("FAIL b2b_first got done %b bcd %h exp 1 045", done, bcd_out); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b exp 1", busy); end
    e = 0;
    while (e < 30) begin
      tick();
      e++;
      if (done) break;
    end
    n_tests++; if (e !== 9) begin n_fail++; $display("FAIL b2b_lat got %0d exp 9", e); end
    n_tests++; if (bcd_out !== 12'h067) begin n_fail++; $display("FAIL b2b_bcd got %h exp 067", bcd_out); end
  endtask

  initial begin
    test_reset();
    test_convert_255();
    test_blanking();
    test_overflow();
    test_blink();
    test_ignore_load();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
